// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle, on
// unsigned magnitudes with a final two's-complement sign fix-up. Divide by
// zero and signed overflow resolve in one cycle without iterating.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 3,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Start,
  input  logic [OP_WIDTH-1:0]   MDControl,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  input  logic                  Flush,
  output logic                  Busy,
  output logic                  Done,
  output logic [DATA_WIDTH-1:0] MDResult,
  output logic                  DivZero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, next_state;

  // captured operation context
  logic [OP_WIDTH-1:0]     op;
  logic [DATA_WIDTH-1:0]   mag_a;
  logic [DATA_WIDTH-1:0]   mag_b;
  logic                    neg_res;
  logic [CNT_WIDTH-1:0]    cnt;
  logic [2*DATA_WIDTH-1:0] acc;

  // request decode
  logic                  accept;
  logic                  signed_a, signed_b;
  logic                  sign_a_in, sign_b_in;
  logic                  in_div, in_rem;
  logic                  neg_in;
  logic                  div_zero_in, ovf_in, fast_in;
  logic [DATA_WIDTH-1:0] abs_a, abs_b;
  logic [DATA_WIDTH-1:0] fast_result;

  // iteration datapath
  logic                    op_div, op_rem;
  logic                    last_iter;
  logic [DATA_WIDTH:0]     trial, diff;
  logic [2*DATA_WIDTH-1:0] acc_step;
  logic [2*DATA_WIDTH-1:0] prod_signed;
  logic [DATA_WIDTH-1:0]   quo, rem;
  logic [DATA_WIDTH-1:0]   final_result;

  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  assign accept    = Start && !Flush && (state != CALC);
  assign in_div    = MDControl[2];
  assign in_rem    = MDControl[2] && MDControl[1];
  assign op_div    = op[2];
  assign op_rem    = op[2] && op[1];
  assign last_iter = (state == CALC) && (cnt == CNT_WIDTH'(DATA_WIDTH - 1));

  assign Busy = (state == CALC);
  assign Done = (state == DONE);

  // Decide which operands of the incoming opcode are treated as signed
  always_comb begin
    signed_a = 1'b0;
    signed_b = 1'b0;
    case (MDControl)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        signed_a = 1'b1;
        signed_b = 1'b1;
      end
      3'b010:  signed_a = 1'b1;
      default: ;
    endcase
  end

  // Operand magnitudes, result sign and the single-cycle special cases
  always_comb begin
    sign_a_in   = signed_a && SrcA[DATA_WIDTH-1];
    sign_b_in   = signed_b && SrcB[DATA_WIDTH-1];
    abs_a       = sign_a_in ? -SrcA : SrcA;
    abs_b       = sign_b_in ? -SrcB : SrcB;
    neg_in      = in_rem ? sign_a_in : (sign_a_in ^ sign_b_in);
    div_zero_in = in_div && (SrcB == '0);
    ovf_in      = in_div && !MDControl[0] && (SrcA == MOST_NEG) && (SrcB == '1);
    fast_in     = div_zero_in || ovf_in;
    fast_result = '0;
    if (div_zero_in)
      fast_result = in_rem ? SrcA : '1;
    else if (ovf_in)
      fast_result = in_rem ? '0 : SrcA;
  end

  // One shift-add or restoring-subtract step, plus the sign-corrected result
  always_comb begin
    trial = {acc[2*DATA_WIDTH-1:DATA_WIDTH], mag_a[DATA_WIDTH-1]};
    diff  = trial - {1'b0, mag_b};
    if (op_div) begin
      // remainder stays below the divisor, so the top bit of diff is the borrow
      acc_step = {(diff[DATA_WIDTH] ? trial[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0]),
                  acc[DATA_WIDTH-2:0], ~diff[DATA_WIDTH]};
    end else begin
      acc_step = (acc << 1) + (mag_b[DATA_WIDTH-1] ? {{DATA_WIDTH{1'b0}}, mag_a} : '0);
    end
    prod_signed = neg_res ? -acc_step : acc_step;
    quo = acc_step[DATA_WIDTH-1:0];
    rem = acc_step[2*DATA_WIDTH-1:DATA_WIDTH];
    if (op_rem)
      final_result = neg_res ? -rem : rem;
    else if (op_div)
      final_result = neg_res ? -quo : quo;
    else if (op[1:0] == 2'b00)
      final_result = prod_signed[DATA_WIDTH-1:0];
    else
      final_result = prod_signed[2*DATA_WIDTH-1:DATA_WIDTH];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= next_state;
  end

  // Next-state logic; Flush wins over everything, including a new Start
  always_comb begin
    next_state = state;
    if (Flush) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (Start)
            next_state = fast_in ? DONE : CALC;
          else
            next_state = IDLE;
        end
        CALC: begin
          if (last_iter)
            next_state = DONE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // Capture operands on accept, then step the accumulator once per CALC cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op      <= '0;
      mag_a   <= '0;
      mag_b   <= '0;
      neg_res <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
    end else if (accept) begin
      op      <= MDControl;
      mag_a   <= abs_a;
      mag_b   <= abs_b;
      neg_res <= neg_in;
      cnt     <= '0;
      acc     <= '0;
    end else if (state == CALC && !Flush) begin
      acc <= acc_step;
      cnt <= cnt + CNT_WIDTH'(1);
      if (op_div)
        mag_a <= mag_a << 1;
      else
        mag_b <= mag_b << 1;
    end
  end

  // Result registers hold until a fast-path or final-iteration write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      MDResult <= '0;
      DivZero  <= 1'b0;
    end else if (accept && fast_in) begin
      MDResult <= fast_result;
      DivZero  <= div_zero_in;
    end else if (last_iter && !Flush) begin
      MDResult <= final_result;
      DivZero  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit, directed cases plus
// randomized operations compared against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        Start;
  logic [2:0]  MDControl;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        Flush;
  logic        Busy;
  logic        Done;
  logic [31:0] MDResult;
  logic        DivZero;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.DATA_WIDTH(32), .OP_WIDTH(3), .CNT_WIDTH(6)) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .MDControl(MDControl),
    .SrcA(SrcA), .SrcB(SrcB), .Flush(Flush), .Busy(Busy), .Done(Done),
    .MDResult(MDResult), .DivZero(DivZero)
  );

  // free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RV32M result computed with plain wide arithmetic
  function automatic logic [31:0] refResult(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    ub = {32'b0, b};
    p  = '0;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFFFFFF; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFFFFFF; return a / b; end
      3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  function automatic int refDoneCycle(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return 33;
  endfunction

  // Issue one op from idle and follow it to Done; optionally pokes a Start while busy
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input int pokeCycle,
                               output logic [31:0] res, output logic dz,
                               output int doneCycle, output int busyCycles);
    int cycle;
    Start = 1'b1; MDControl = op; SrcA = a; SrcB = b; Flush = 1'b0;
    @(posedge clk); #1;
    Start = 1'b0; SrcA = $urandom; SrcB = $urandom; MDControl = 3'($urandom);
    cycle = 1; doneCycle = -1; busyCycles = 0; res = '0; dz = 1'b0;
    while (cycle <= 80) begin
      Start = 1'b0;
      if (Busy) busyCycles++;
      if (Done) begin
        doneCycle = cycle; res = MDResult; dz = DivZero;
        break;
      end
      if (cycle == pokeCycle) begin
        Start = 1'b1; MDControl = 3'($urandom); SrcA = $urandom; SrcB = 32'd0;
      end
      @(posedge clk); #1;
      cycle++;
    end
    Start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; Start = 1'b0; Flush = 1'b0; MDControl = '0; SrcA = '0; SrcB = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (Busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", Done); end
    checks++; if (MDResult !== 32'h0) begin errors++; $display("[TB] FAIL reset_result got %h want 0", MDResult); end
    checks++; if (DivZero !== 1'b0) begin errors++; $display("[TB] FAIL reset_divzero got %b want 0", DivZero); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [2:0]  ops  [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd6, 3'd4};
    logic [31:0] as   [9] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9,
                              32'hFFFFFFF9, 32'd5, 32'd5, 32'h80000000};
    logic [31:0] bs   [9] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2,
                              32'd2, 32'd0, 32'd0, 32'hFFFFFFFF};
    logic [31:0] exps [9] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFD,
                              32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 32'h80000000};
    logic        dzs  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int          dcs  [9] = '{33, 33, 33, 33, 33, 33, 1, 1, 1};
    logic [31:0] res; logic dz; int dc, bc;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(ops[i], as[i], bs[i], -1, res, dz, dc, bc);
      checks++; if (res !== exps[i]) begin errors++; $display("[TB] FAIL directed%0d_result got %h want %h", i, res, exps[i]); end
      checks++; if (dz !== dzs[i]) begin errors++; $display("[TB] FAIL directed%0d_divzero got %b want %b", i, dz, dzs[i]); end
      checks++; if (dc != dcs[i]) begin errors++; $display("[TB] FAIL directed%0d_done_cycle got %0d want %0d", i, dc, dcs[i]); end
      checks++; if (bc != dcs[i] - 1) begin errors++; $display("[TB] FAIL directed%0d_busy_cycles got %0d want %0d", i, bc, dcs[i] - 1); end
    end
  endtask

  task automatic test_back_to_back();
    int cycle, first, second;
    logic [31:0] r1, r2;
    Start = 1'b1; MDControl = 3'd5; SrcA = 32'd100; SrcB = 32'd7;
    @(posedge clk); #1;
    Start = 1'b0; SrcA = $urandom; SrcB = $urandom;
    cycle = 1; first = -1; second = -1; r1 = '0; r2 = '0;
    while (cycle <= 140 && second < 0) begin
      Start = 1'b0;
      if (Done) begin
        if (first < 0) begin
          first = cycle; r1 = MDResult;
          Start = 1'b1; MDControl = 3'd7; SrcA = 32'd100; SrcB = 32'd7;
        end else begin
          second = cycle; r2 = MDResult;
        end
      end
      if (second < 0) begin @(posedge clk); #1; cycle++; end
    end
    Start = 1'b0;
    checks++; if (first != 33) begin errors++; $display("[TB] FAIL b2b_first_done got %0d want 33", first); end
    checks++; if (r1 !== 32'd14) begin errors++; $display("[TB] FAIL b2b_divu got %0d want 14", r1); end
    checks++; if (second != 66) begin errors++; $display("[TB] FAIL b2b_second_done got %0d want 66", second); end
    checks++; if (r2 !== 32'd2) begin errors++; $display("[TB] FAIL b2b_remu got %0d want 2", r2); end
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    logic [31:0] res; logic dz; int dc, bc, cycle; logic sawDone, sawBusy;
    applyStimulus(3'd5, 32'd100, 32'd7, -1, res, dz, dc, bc);
    Start = 1'b1; MDControl = 3'd0; SrcA = 32'd1234; SrcB = 32'd5678;
    @(posedge clk); #1;
    Start = 1'b0;
    cycle = 1;
    while (cycle < 10) begin @(posedge clk); #1; cycle++; end
    Flush = 1'b1;
    @(posedge clk); #1;
    Flush = 1'b0;
    checks++; if (Busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_busy got %b want 0", Busy); end
    sawDone = 1'b0;
    for (int i = 0; i < 40; i++) begin sawDone |= Done; @(posedge clk); #1; end
    checks++; if (sawDone !== 1'b0) begin errors++; $display("[TB] FAIL flush_no_done got %b want 0", sawDone); end
    checks++; if (MDResult !== 32'd14) begin errors++; $display("[TB] FAIL flush_result_hold got %h want %h", MDResult, 32'd14); end
    // Start and Flush together while idle must not launch anything
    Start = 1'b1; Flush = 1'b1; MDControl = 3'd0; SrcA = 32'd3; SrcB = 32'd3;
    @(posedge clk); #1;
    Start = 1'b0; Flush = 1'b0;
    sawBusy = 1'b0; sawDone = 1'b0;
    for (int i = 0; i < 4; i++) begin sawBusy |= Busy; sawDone |= Done; @(posedge clk); #1; end
    checks++; if (sawBusy !== 1'b0) begin errors++; $display("[TB] FAIL flush_start_busy got %b want 0", sawBusy); end
    checks++; if (sawDone !== 1'b0) begin errors++; $display("[TB] FAIL flush_start_done got %b want 0", sawDone); end
  endtask

  task automatic test_start_while_busy();
    logic [31:0] res, a, b; logic dz; int dc, bc;
    a = 32'h12345678; b = 32'h9ABCDEF0;
    applyStimulus(3'd3, a, b, 5, res, dz, dc, bc);
    checks++; if (res !== refResult(3'd3, a, b)) begin errors++; $display("[TB] FAIL busy_start_result got %h want %h", res, refResult(3'd3, a, b)); end
    checks++; if (dc != 33) begin errors++; $display("[TB] FAIL busy_start_done_cycle got %0d want 33", dc); end
  endtask

  task automatic test_async_reset();
    logic [31:0] res; logic dz; int dc, bc;
    applyStimulus(3'd5, 32'd5, 32'd0, -1, res, dz, dc, bc);
    Start = 1'b1; MDControl = 3'd0; SrcA = 32'h1234; SrcB = 32'h5678;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (14) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (Busy !== 1'b0) begin errors++; $display("[TB] FAIL areset_busy got %b want 0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("[TB] FAIL areset_done got %b want 0", Done); end
    checks++; if (MDResult !== 32'h0) begin errors++; $display("[TB] FAIL areset_result got %h want 0", MDResult); end
    checks++; if (DivZero !== 1'b0) begin errors++; $display("[TB] FAIL areset_divzero got %b want 0", DivZero); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(3'd0, 32'd3, 32'd4, -1, res, dz, dc, bc);
    checks++; if (res !== 32'd12) begin errors++; $display("[TB] FAIL areset_mul got %0d want 12", res); end
    checks++; if (dc != 33) begin errors++; $display("[TB] FAIL areset_mul_done got %0d want 33", dc); end
  endtask

  task automatic test_random();
    logic [2:0] op; logic [31:0] a, b, res, expRes; logic dz, expDz; int dc, bc, expDc;
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: b = -32'($urandom_range(1, 15));
        default: ;
      endcase
      expRes = refResult(op, a, b);
      expDz  = op[2] && (b == 32'd0);
      expDc  = refDoneCycle(op, a, b);
      applyStimulus(op, a, b, -1, res, dz, dc, bc);
      checks++; if (res !== expRes) begin errors++; $display("[TB] FAIL rand%0d_result op=%0d a=%h b=%h got %h want %h", i, op, a, b, res, expRes); end
      checks++; if (dz !== expDz) begin errors++; $display("[TB] FAIL rand%0d_divzero got %b want %b", i, dz, expDz); end
      checks++; if (dc != expDc) begin errors++; $display("[TB] FAIL rand%0d_done_cycle got %0d want %0d", i, dc, expDc); end
    end
  endtask

  // run every scenario in order, then report
  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_flush();
    test_start_while_busy();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
